// File: rtl/vnu.sv
// Variable node unit: two-stage pipeline forming the total LLR, the
// extrinsic variable-to-check messages, the saturated APP and the hard decision.
module vnu #(
   parameter int D      = 3,
   parameter int data_w = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [data_w-1:0]     lch,
   input  logic [data_w*D-1:0]   r,
   output logic                  out_valid,
   output logic [data_w*D-1:0]   q,
   output logic [data_w-1:0]     app,
   output logic                  hd
);

   localparam int sw = data_w + $clog2(D + 1) + 1;

   // Symmetric clamp bounds; -2^(data_w-1) is deliberately never produced.
   localparam logic signed [sw-1:0] sat_max = {{(sw - data_w + 1){1'b0}}, {(data_w - 1){1'b1}}};
   localparam logic signed [sw-1:0] sat_min = -sat_max;

   function automatic logic [data_w-1:0] sat(input logic signed [sw-1:0] x);
      logic [data_w-1:0] y;
      if (x > sat_max)
         y = sat_max[data_w-1:0];
      else if (x < sat_min)
         y = sat_min[data_w-1:0];
      else
         y = x[data_w-1:0];
      return y;
   endfunction

   logic signed [sw-1:0]     lch_ext;
   logic signed [sw-1:0]     r_ext   [D];
   logic signed [sw-1:0]     r1_ext  [D];
   logic signed [sw-1:0]     tot_next;
   logic [data_w*D-1:0]      q_next;

   logic                     v1_reg;
   logic signed [sw-1:0]     tot_reg;
   logic [data_w-1:0]        r1_reg  [D];
   logic                     out_valid_reg;
   logic [data_w*D-1:0]      q_reg;
   logic [data_w-1:0]        app_reg;
   logic                     hd_reg;

   assign lch_ext = {{(sw - data_w){lch[data_w-1]}}, lch};

   genvar gi;
   generate
      for (gi = 0; gi < D; gi++) begin : g_word
         assign r_ext[gi]  = {{(sw - data_w){r[gi*data_w + data_w - 1]}}, r[gi*data_w +: data_w]};
         assign r1_ext[gi] = {{(sw - data_w){r1_reg[gi][data_w-1]}}, r1_reg[gi]};
         assign q_next[gi*data_w +: data_w] = sat(tot_reg - r1_ext[gi]);
      end
   endgenerate

   always_comb begin
      tot_next = lch_ext;
      for (int i = 0; i < D; i++)
         tot_next = tot_next + r_ext[i];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_reg  <= 1'b0;
         tot_reg <= '0;
         for (int i = 0; i < D; i++)
            r1_reg[i] <= '0;
      end else if (en) begin
         v1_reg  <= in_valid;
         tot_reg <= tot_next;
         for (int i = 0; i < D; i++)
            r1_reg[i] <= r[i*data_w +: data_w];
      end
   end

   // Outputs only reload on a valid beat so a bubble leaves the last result visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_reg <= 1'b0;
         q_reg         <= '0;
         app_reg       <= '0;
         hd_reg        <= 1'b0;
      end else if (en) begin
         out_valid_reg <= v1_reg;
         if (v1_reg) begin
            q_reg   <= q_next;
            app_reg <= sat(tot_reg);
            hd_reg  <= tot_reg[sw-1];
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign q         = q_reg;
   assign app       = app_reg;
   assign hd        = hd_reg;

endmodule

// File: tb/tb_vnu.sv
// Scoreboard bench for vnu: driver pushes expected results, monitor pops and
// compares each new output and checks that outputs hold between results.
module tb_vnu;

   typedef struct packed {
      logic [23:0] q;
      logic [7:0]  app;
      logic        hd;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  lch = '0;
   logic [23:0] r = '0;
   logic        out_valid;
   logic [23:0] q;
   logic [7:0]  app;
   logic        hd;

   int n_cmp = 0;
   int n_bad = 0;
   exp_t sb[$];

   vnu #(.D(3), .data_w(8)) dut (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
      .lch(lch), .r(r), .out_valid(out_valid), .q(q), .app(app), .hd(hd)
   );

   always #5 clk = ~clk;

   // Directed vectors: lch, r0, r1, r2, q0, q1, q2, app, hd (hand computed)
   int vec [8][9] = '{
      '{  10,    5,   -3,    7,   14,   22,   12,   19, 0},
      '{ 127,  127,  127,  127,  127,  127,  127,  127, 0},
      '{-128, -128, -128, -128, -127, -127, -127, -127, 1},
      '{  -5,    3,    1,    1,   -3,   -1,   -1,    0, 0},
      '{  -6,    3,    1,    1,   -4,   -2,   -2,   -1, 1},
      '{   0,    0,    0,    0,    0,    0,    0,    0, 0},
      '{ 100, -128,   50,  -20,  127,  -48,   22,    2, 0},
      '{-100, -100, -100,  100, -100, -100, -127, -127, 1}
   };

   function automatic logic [7:0] sat8(input int x);
      int y;
      y = (x > 127) ? 127 : (x < -127) ? -127 : x;
      return y[7:0];
   endfunction

   function automatic exp_t model(input int l, input int a, input int b, input int c);
      exp_t e;
      int   t;
      t = l + a + b + c;
      e.q   = {sat8(t - c), sat8(t - b), sat8(t - a)};
      e.app = sat8(t);
      e.hd  = (t < 0);
      return e;
   endfunction

   function automatic exp_t hand(input int k);
      exp_t e;
      int   v0, v1, v2, v3;
      v0 = vec[k][4]; v1 = vec[k][5]; v2 = vec[k][6]; v3 = vec[k][7];
      e.q   = {v2[7:0], v1[7:0], v0[7:0]};
      e.app = v3[7:0];
      e.hd  = (vec[k][8] != 0);
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of inputs 2 time units after the rising edge.
   task automatic step(input logic e, input logic v, input int l, input int a, input int b, input int c);
      @(posedge clk);
      #2;
      en       = e;
      in_valid = v;
      lch      = l[7:0];
      r        = {c[7:0], b[7:0], a[7:0]};
      if (e && v)
         sb.push_back(model(l, a, b, c));
   endtask

   task automatic send_hand(input int k);
      @(posedge clk);
      #2;
      en       = 1'b1;
      in_valid = 1'b1;
      lch      = vec[k][0][7:0];
      r        = {vec[k][3][7:0], vec[k][2][7:0], vec[k][1][7:0]};
      sb.push_back(hand(k));
   endtask

   // Monitor: tracks expected valid timing and compares 1 unit after each edge.
   initial begin : monitor
      logic s1v, exp_ov, en_s, iv_s, rst_s;
      exp_t last, e;
      s1v = 1'b0; exp_ov = 1'b0; last = '0;
      forever begin
         @(posedge clk);
         en_s = en; iv_s = in_valid; rst_s = rst;
         #1;
         if (!rst_s) begin
            s1v = 1'b0; exp_ov = 1'b0; last = '0;
         end else if (en_s) begin
            exp_ov = s1v;
            if (s1v) begin
               if (sb.size() == 0) begin
                  n_cmp++; n_bad++;
                  $display("FAIL scoreboard_underflow: got beat, required none at %0t", $time);
               end else begin
                  e = sb.pop_front();
                  last = e;
               end
            end
            s1v = iv_s;
         end
         check("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
         check("q",   {8'd0, q},    {8'd0, last.q});
         check("app", {24'd0, app}, {24'd0, last.app});
         check("hd",  {31'd0, hd},  {31'd0, last.hd});
         if (exp_ov && en_s && rst_s)
            $display("beat q=%h app=%h hd=%b", q, app, hd);
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish");
      $fatal(1, "timeout");
   end

   initial begin : driver
      #1;
      check("reset_out_valid", {31'd0, out_valid}, 32'd0);
      check("reset_q", {8'd0, q}, 32'd0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;

      // Directed vectors back-to-back
      for (int k = 0; k < 8; k++)
         send_hand(k);
      step(1, 0, 0, 0, 0, 0);
      repeat (3) step(1, 0, 0, 0, 0, 0);

      // Stall: A, B back-to-back, 3 stalled cycles with a beat that must be dropped
      step(1, 1, 20, 1, 2, 3);
      step(1, 1, -40, -1, -2, -3);
      repeat (3) step(0, 1, 77, 77, 77, 77);
      repeat (4) step(1, 0, 0, 0, 0, 0);

      // Reset mid-stream with two beats in flight
      step(1, 1, 9, 9, 9, 9);
      step(1, 1, -9, -9, -9, -9);
      @(posedge clk);
      #5;
      rst = 1'b0;
      sb.delete();
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_q", {8'd0, q}, 32'd0);
      check("rst_app", {24'd0, app}, 32'd0);
      check("rst_hd", {31'd0, hd}, 32'd0);
      en = 1'b1; in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (3) step(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      en = 1'b1; in_valid = 1'b1; lch = 8'd1; r = {8'd1, 8'd1, 8'd1};
      sb.push_back(exp_t'{q: {8'd3, 8'd3, 8'd3}, app: 8'd4, hd: 1'b0});
      repeat (4) step(1, 0, 0, 0, 0, 0);

      // Random regression with extreme values favoured
      for (int n = 0; n < 10000; n++) begin
         int v [4];
         for (int j = 0; j < 4; j++) begin
            case ($urandom_range(0, 3))
               0: v[j] = -128;
               1: v[j] = 127;
               default: v[j] = int'($urandom_range(0, 255)) - 128;
            endcase
         end
         step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, v[0], v[1], v[2], v[3]);
      end
      repeat (4) step(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #3;
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vnu.md
# vnu

Variable node unit for the layered min-sum LDPC decoder. Each accepted beat carries one channel LLR and the D check-to-variable messages addressed to that variable node. The block produces the D variable-to-check messages, the saturated a-posteriori LLR and the hard-decision bit. It is the counterpart of the check node unit: its `q` output feeds the CNU `q` input, and its `r` input is fed by the CNU `r` output, using the same packing and word width.

## Interface
- `D`, 3: variable-node degree, i.e. the number of check messages per beat; must be at least 2.
- `data_w`, 8: width of each two's-complement message and of the channel LLR.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `en`  in  1  pipeline advance; 0 freezes every register, including the valid bits.
- `in_valid`  in  1  beat qualifier for `lch` and `r`.
- `lch`  in  data_w  channel LLR, two's complement.
- `r`  in  data_w*D  check messages; word i is at bits [i*data_w +: data_w].
- `out_valid`  out  1  qualifies `q`, `app` and `hd`.
- `q`  out  data_w*D  variable-to-check messages, same packing as `r`.
- `app`  out  data_w  saturated a-posteriori LLR.
- `hd`  out  1  hard decision; 1 when the unsaturated total is negative.

## Operation
- Sum width: `sw = data_w + log2ceil(D+1) + 1`. All sums are sign-extended to `sw` bits, so no intermediate overflow is possible.
- Stage 1, on a cycle with en=1:
  - register `tot = lch + sum(r[i])`;
  - register a copy of every r[i];
  - register v1 = in_valid.
- Stage 2, on a cycle with en=1:
  - `q[i] = sat(tot - r1[i])`;
  - `app = sat(tot)`;
  - `hd = tot[sw-1]`;
  - out_valid = v1.
- sat() clamps to the symmetric range [-(2^(data_w-1)-1), +(2^(data_w-1)-1)]. For data_w=8 that is [-127, 127].
  - The code -2^(data_w-1) is never emitted, so the CNU absolute-value stage cannot overflow.
  - -2^(data_w-1) is still accepted on the inputs as an ordinary value.
- Stage 2 registers load only when v1=1 and en=1. When v1=0 and en=1, out_valid drops to 0 and q/app/hd hold their last values.
- en=0: both stages hold their contents, and out_valid holds its value. A beat presented while en=0 is ignored; it is not captured.
- No backpressure exists. The upstream scheduler must hold the beat, or re-present it, while en=0.
- hd comes from the sign of the full-width total, not from app. A total of exactly 0 gives hd=0.

## Timing
- Latency is 2 en-qualified edges: a beat with in_valid=1 captured at edge N appears with out_valid=1 after edge N+1, provided en=1 at both edges.
- Throughput is one beat per enabled cycle. Back-to-back beats emerge back-to-back, in order.
- Reset (rst=0), immediately and regardless of clk:
  - v1, out_valid, q, app and hd are all 0;
  - tot and the r copies are 0.
- Reset mid-stream discards every in-flight beat.
- After rst rises, the first edge with en=1 and in_valid=1 starts a normal beat; out_valid stays 0 until that beat reaches stage 2.
- rst deasserting on the same edge as an in_valid beat: the beat is captured only if rst was already high at that edge. The bench avoids driving this race.
- Simultaneous en=0 and in_valid=1: the beat is dropped and the pipeline is unchanged.

## Test plan
- Nominal (D=3, data_w=8): lch=10, r=(5,-3,7), en=1.
  - Required 2 cycles later: out_valid=1, tot=19, q=(14,22,12), app=19, hd=0.
- Positive saturation: lch=127, r=(127,127,127).
  - Required: q=(127,127,127), app=127, hd=0.
  - Negative saturation: lch=-128, r=(-128,-128,-128) gives q=(-127,-127,-127), app=-127, hd=1.
- Sign/zero edge cases:
  - lch=-5, r=(3,1,1) gives tot=0, hd=0, app=0, q=(-3,-1,-1).
  - lch=-6, same r, gives tot=-1, hd=1, app=-1, q=(-4,-2,-2).
- Stall: send beats A and B back-to-back, then hold en=0 for 3 cycles after A is captured.
  - Required: out_valid and q frozen during the 3 stall cycles.
  - Required: A then B emerge in order once en returns.
  - A beat presented during the stall does not appear at the output.
- Reset mid-stream: pull rst low asynchronously, between clock edges, while two beats are in flight.
  - Required: out_valid=0, q=0, app=0, hd=0 at once.
  - Required: no stale beat after release.
  - A fresh beat lch=1, r=(1,1,1) then yields q=(3,3,3), app=4.
- Random regression: 10k beats with random en/in_valid, compared against a reference model.
  - Check that -128 never appears on `q` or `app`.
